// File: rtl/prsim_chan_driver.sv
// Multi-channel four-phase handshake driver: commands request N tokens on a channel,
// and each channel runs its own req/ack handshake with a per-phase timeout.
module prsim_chan_lane #(
  parameter int CW      = 8,
  parameter int TOW     = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] count,
  input  logic          ack,
  input  logic          err_clr,
  output logic          req,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          idle,
  output logic          tok
);
  typedef enum logic [1:0] {IDLE, RISE, FALL, ERR} state_t;

  state_t         state, state_n;
  logic [1:0]     ack_pipe;
  logic           ack_s, tmo;
  logic [CW-1:0]  rem, rem_n;
  logic [TOW-1:0] tcnt, tcnt_n;
  logic           req_n, done_n, err_n;

  assign ack_s = ack_pipe[1];
  assign tmo   = (tcnt == TOW'(TIMEOUT - 1));
  assign idle  = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_pipe <= '0;
      state    <= IDLE;
      rem      <= '0;
      tcnt     <= '0;
      req      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      ack_pipe <= {ack_pipe[0], ack};
      state    <= state_n;
      rem      <= rem_n;
      tcnt     <= tcnt_n;
      req      <= req_n;
      busy     <= (state_n != IDLE);
      done     <= done_n;
      err      <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    rem_n   = rem;
    tcnt_n  = tcnt;
    req_n   = req;
    done_n  = 1'b0;
    err_n   = err;
    tok     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            done_n = 1'b1;
          end else begin
            rem_n   = count;
            state_n = RISE;
            req_n   = 1'b1;
            tcnt_n  = '0;
          end
        end
      end
      RISE: begin
        tcnt_n = tcnt + 1'b1;
        if (ack_s) begin
          req_n   = 1'b0;
          state_n = FALL;
          tcnt_n  = '0;
        end else if (tmo) begin
          req_n   = 1'b0;
          err_n   = 1'b1;
          state_n = ERR;
        end
      end
      FALL: begin
        tcnt_n = tcnt + 1'b1;
        if (!ack_s) begin
          tok    = 1'b1;
          tcnt_n = '0;
          if (rem == CW'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            rem_n   = rem - 1'b1;
            state_n = RISE;
            req_n   = 1'b1;
          end
        end else if (tmo) begin
          req_n   = 1'b0;
          err_n   = 1'b1;
          state_n = ERR;
        end
      end
      ERR: begin
        req_n = 1'b0;
        if (err_clr) begin
          err_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

module prsim_chan_driver #(
  parameter int NCH     = 2,
  parameter int CW      = 8,
  parameter int TOW     = 16,
  parameter int TIMEOUT = 1000,
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [CHW-1:0] cmd_ch,
  input  logic [CW-1:0]  cmd_count,
  output logic [NCH-1:0] req,
  input  logic [NCH-1:0] ack,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] done,
  output logic [NCH-1:0] err,
  input  logic [NCH-1:0] err_clr,
  output logic [15:0]    sent_total
);
  logic [NCH-1:0] sel, idle, start, tok;
  logic [15:0]    tok_cnt;

  // out-of-range cmd_ch matches no lane, so it is never ready
  assign cmd_ready = |(sel & idle);
  assign start     = sel & idle & {NCH{cmd_valid}};

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    assign sel[i] = (cmd_ch == CHW'(i));
    prsim_chan_lane #(.CW(CW), .TOW(TOW), .TIMEOUT(TIMEOUT)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start[i]),
      .count   (cmd_count),
      .ack     (ack[i]),
      .err_clr (err_clr[i]),
      .req     (req[i]),
      .busy    (busy[i]),
      .done    (done[i]),
      .err     (err[i]),
      .idle    (idle[i]),
      .tok     (tok[i])
    );
  end

  always_comb begin
    tok_cnt = '0;
    for (int i = 0; i < NCH; i++) tok_cnt = tok_cnt + 16'(tok[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sent_total <= '0;
    else        sent_total <= sent_total + tok_cnt;
  end
endmodule

// File: doc/prsim_chan_driver.md
PRSIM_CHAN_DRIVER -- requirements
Module: prsim_chan_driver

Interface
REQ-001 SHALL have parameter NCH, default 2: number of independent four-phase output channels.
REQ-002 SHALL have parameter CW, default 8: token-count width.
REQ-003 SHALL have parameter TOW, default 16: timeout-counter width.
REQ-004 SHALL have parameter TIMEOUT, default 1000: cycles allowed per ack phase, range 1..2^TOW-1.
REQ-005 SHALL have ports as follows (one clock; reset is asynchronous and active-low):
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  cmd_valid  in  1  command offered
  cmd_ready  out  1  command accepted this cycle if cmd_valid
  cmd_ch  in  max(1,clog2(NCH))  target channel
  cmd_count  in  CW  tokens to emit
  req  out  NCH  four-phase request per channel, to co-simulated circuit
  ack  in  NCH  four-phase acknowledge per channel, asynchronous
  busy  out  NCH  channel not IDLE
  done  out  NCH  one-cycle pulse, command complete
  err  out  NCH  sticky timeout flag
  err_clr  in  NCH  per-channel error clear
  sent_total  out  16  tokens completed, all channels

Function
REQ-006 SHALL synchronise each ack bit through a 2-flop synchroniser (ack_s) before any use.
REQ-007 SHALL run one FSM per channel with states IDLE, RISE, FALL, ERR.
REQ-008 SHALL drive cmd_ready = cmd_valid-independent: 1 iff cmd_ch < NCH and channel cmd_ch is IDLE.
REQ-009 SHALL, on accept with cmd_count = 0, stay IDLE, leave req low and pulse done[ch] on the next cycle.
REQ-010 SHALL, on accept with cmd_count > 0, load remaining = cmd_count, enter RISE and drive req[ch] = 1 from that same edge.
REQ-011 SHALL, in RISE with ack_s = 1, drive req low and enter FALL.
REQ-012 SHALL, in FALL with ack_s = 0, increment sent_total (mod 2^16), and: if remaining = 1, enter IDLE and pulse done[ch] for one cycle; else decrement remaining, enter RISE and drive req high.
REQ-013 SHALL clear the channel timeout counter on every entry to RISE or FALL and increment it each cycle in those states.
REQ-014 SHALL, if the counter reaches TIMEOUT without the awaited ack_s level, enter ERR, drive req low, set err[ch]; no done pulse, sent_total unchanged.
REQ-015 SHALL hold busy[ch] = 1 in RISE, FALL and ERR.
REQ-016 SHALL, in ERR with err_clr[ch] = 1, clear err[ch] and enter IDLE; err_clr outside ERR SHALL have no effect.
REQ-017 SHALL treat channels fully independently; simultaneous completions on several channels in one cycle SHALL each add 1 to sent_total (add popcount).
REQ-018 SHALL ignore ack changes while IDLE or ERR (no state change, no count).
REQ-019 SHALL produce registered req, busy, done, err outputs (no combinational path from ack).

Reset
REQ-020 SHALL, on rst_n low, asynchronously force all FSMs to IDLE, req = 0, busy = 0, done = 0, err = 0, sent_total = 0, synchronisers = 0, remaining = 0, timeout counters = 0.
REQ-021 SHALL, on reset mid-handshake, abandon the transfer with no done pulse; cmd_ready SHALL be 1 for a valid channel on the first cycle after rst_n rises.

Verification
REQ-022 Single token: ch0 count=1, ack echoes req after 3 cycles -> req0 1 then 0, done0 pulses once, sent_total = 1.
REQ-023 Burst plus concurrency: ch0 count=3 and ch1 count=2 back to back, both acked -> exactly 3 and 2 req pulses, two done pulses, sent_total = 5, cmd_ready low for busy channel.
REQ-024 Zero count: count=0 on ch1 -> no req activity, done1 pulses next cycle, sent_total unchanged.
REQ-025 Timeout: TIMEOUT=8, ack0 never rises -> err0 = 1 after 8 cycles in RISE, req0 = 0, busy0 = 1; err_clr0 -> IDLE, cmd_ready = 1.
REQ-026 Reset mid-operation: rst_n low during FALL of a count=4 command -> all outputs 0 immediately, no done, new command accepted after release.
REQ-027 Illegal channel: cmd_ch = NCH (NCH = 3) -> cmd_ready = 0, no state change.
